// File: rtl/vthernet_pkg.sv
// Shared constants and types for the Vthernet receive path.
package vthernet_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CRC_W  = 32;

  localparam logic [7:0]       PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]       SFD_BYTE      = 8'hD5;
  localparam logic [CRC_W-1:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  // End-of-frame status reported alongside frame_done.
  typedef struct packed {
    logic              ok;
    logic              crc_err;
    logic              len_err;
    logic              phy_err;
    logic [ADDR_W-1:0] len;
  } frame_status_t;

endpackage

// File: rtl/rx_gmii_framer_if.sv
// GMII receive inputs plus SRAM write / frame status outputs of the framer.
interface rx_gmii_framer_if;
  import vthernet_pkg::*;

  logic              RX_DV;
  logic [7:0]        RXD;
  logic              RX_ER;

  logic              rx_data_v;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] rx_addr;
  logic              frame_done;
  logic              frame_ok;
  logic [ADDR_W-1:0] frame_len;
  logic              crc_err;
  logic              len_err;
  logic              phy_err;

  modport master (
    input  RX_DV, RXD, RX_ER,
    output rx_data_v, rx_data, rx_addr,
    output frame_done, frame_ok, frame_len, crc_err, len_err, phy_err
  );

  modport slave (
    output RX_DV, RXD, RX_ER,
    input  rx_data_v, rx_data, rx_addr,
    input  frame_done, frame_ok, frame_len, crc_err, len_err, phy_err
  );

endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 update, LSB of the data byte shifted in first.
module crc32_d8
  import vthernet_pkg::*;
(
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC_POLY;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/rx_gmii_framer.sv
// GMII receive framer: strips preamble/SFD, writes frame bytes to SRAM,
// checks FCS residue and length, and reports per-frame status.
module rx_gmii_framer
  import vthernet_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic             RX_CLK,
  input  logic             rst,
  rx_gmii_framer_if.master bus
);

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] MIN_CNT = ADDR_W'(MIN_LEN);

  logic [1:0]        state,   state_d;
  logic [ADDR_W-1:0] count,   count_d;
  logic [CRC_W-1:0]  crc,     crc_d;
  logic [CRC_W-1:0]  crc_nxt;
  logic              phy_l,   phy_l_d;
  logic              len_l,   len_l_d;
  logic              wr_v,    wr_v_d;
  logic [7:0]        wr_data, wr_data_d;
  logic [ADDR_W-1:0] wr_addr, wr_addr_d;
  logic              done,    done_d;
  frame_status_t     stat,    stat_d;
  logic              crc_bad;
  logic              short_frame;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (bus.RXD),
    .crc_out (crc_nxt)
  );

  assign crc_bad     = (crc != CRC_RESIDUE);
  assign short_frame = (count < MIN_CNT);

  // State and registered outputs
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      crc     <= CRC_INIT;
      phy_l   <= 1'b0;
      len_l   <= 1'b0;
      wr_v    <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      done    <= 1'b0;
      stat    <= '0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      crc     <= crc_d;
      phy_l   <= phy_l_d;
      len_l   <= len_l_d;
      wr_v    <= wr_v_d;
      wr_data <= wr_data_d;
      wr_addr <= wr_addr_d;
      done    <= done_d;
      stat    <= stat_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state;
    count_d   = count;
    crc_d     = crc;
    phy_l_d   = phy_l;
    len_l_d   = len_l;
    wr_v_d    = 1'b0;
    wr_data_d = wr_data;
    wr_addr_d = wr_addr;
    done_d    = 1'b0;
    stat_d    = stat;

    case (state)
      ST_IDLE: begin
        if (bus.RX_DV && (bus.RXD == PREAMBLE_BYTE)) state_d = ST_PREAMBLE;
      end

      ST_PREAMBLE: begin
        if (!bus.RX_DV) begin
          state_d = ST_IDLE;
        end else if (bus.RXD == PREAMBLE_BYTE) begin
          state_d = ST_PREAMBLE;
        end else begin
          // A bad SFD still produces a frame_done, with no cause flagged.
          state_d = (bus.RXD == SFD_BYTE) ? ST_DATA : ST_DROP;
          count_d = '0;
          crc_d   = CRC_INIT;
          phy_l_d = 1'b0;
          len_l_d = 1'b0;
        end
      end

      ST_DATA: begin
        if (!bus.RX_DV) begin
          state_d        = ST_IDLE;
          done_d         = 1'b1;
          stat_d.len     = count;
          stat_d.crc_err = crc_bad;
          stat_d.len_err = len_l | short_frame;
          stat_d.phy_err = phy_l;
          stat_d.ok      = ~(crc_bad | len_l | short_frame | phy_l);
        end else if (bus.RX_ER) begin
          state_d = ST_DROP;
          phy_l_d = 1'b1;
        end else if (count == MAX_CNT) begin
          state_d = ST_DROP;
          len_l_d = 1'b1;
        end else begin
          wr_v_d    = 1'b1;
          wr_data_d = bus.RXD;
          wr_addr_d = count;
          count_d   = count + ADDR_W'(1);
          crc_d     = crc_nxt;
        end
      end

      ST_DROP: begin
        if (!bus.RX_DV) begin
          state_d        = ST_IDLE;
          done_d         = 1'b1;
          stat_d.len     = count;
          stat_d.crc_err = 1'b0;
          stat_d.len_err = len_l;
          stat_d.phy_err = phy_l;
          stat_d.ok      = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rx_data_v  = wr_v;
  assign bus.rx_data    = wr_data;
  assign bus.rx_addr    = wr_addr;
  assign bus.frame_done = done;
  assign bus.frame_ok   = stat.ok;
  assign bus.frame_len  = stat.len;
  assign bus.crc_err    = stat.crc_err;
  assign bus.len_err    = stat.len_err;
  assign bus.phy_err    = stat.phy_err;

endmodule

// File: tb/tb_rx_gmii_framer.sv
// Directed scoreboard bench for rx_gmii_framer.
module tb_rx_gmii_framer;

  typedef struct packed {
    logic        ok;
    logic        crc_err;
    logic        len_err;
    logic        phy_err;
    logic [10:0] len;
  } res_t;

  localparam int MAX_LEN = 1522;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_gmii_framer_if bus ();

  rx_gmii_framer #(.MAX_LEN(1522), .MIN_LEN(64)) dut (
    .RX_CLK (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [18:0] wq[$];
  res_t        rq[$];
  logic [7:0]  frm[$];
  int          checks   = 0;
  int          failures = 0;
  bit          prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic res_t mk(input bit ok, input bit ce, input bit le, input bit pe, input int len);
    res_t r;
    r.ok = ok; r.crc_err = ce; r.len_err = le; r.phy_err = pe; r.len = 11'(len);
    return r;
  endfunction

  // Fills frm with n bytes: n-4 payload bytes then the Ethernet FCS.
  task automatic make_frame(input int n, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      b = 8'((i * seed + 7) & 255);
      frm.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.RX_DV = 1'b0; bus.RX_ER = 1'b0; bus.RXD = 8'h00;
    end
  endtask

  task automatic preamble(input bit er_pre);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.RX_DV = 1'b1; bus.RXD = 8'h55; bus.RX_ER = er_pre && (k == 2);
    end
  endtask

  task automatic send(input int er_at, input logic [7:0] sfd, input bit er_pre, input res_t e);
    int cnt;
    bit drop;
    cnt  = 0;
    drop = 1'b0;
    preamble(er_pre);
    @(negedge clk);
    bus.RXD = sfd; bus.RX_ER = 1'b0;
    if (sfd == 8'hD5) begin
      for (int i = 0; i < frm.size(); i++) begin
        @(negedge clk);
        bus.RXD = frm[i]; bus.RX_ER = (i == er_at);
        if (!drop) begin
          if (i == er_at || cnt == MAX_LEN) drop = 1'b1;
          else begin
            wq.push_back({11'(cnt), frm[i]});
            cnt++;
          end
        end
      end
    end
    @(negedge clk);
    bus.RX_DV = 1'b0; bus.RX_ER = 1'b0; bus.RXD = 8'h00;
    rq.push_back(e);
  endtask

  // Output monitor: pops write and status expectations as the DUT produces them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_data_v) begin
        chk("write_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) chk("write_addr_data", 32'({bus.rx_addr, bus.rx_data}), 32'(wq.pop_front()));
      end
      if (bus.frame_done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        chk("done_expected", 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0)
          chk("frame_status", 32'({bus.frame_ok, bus.crc_err, bus.len_err, bus.phy_err, bus.frame_len}),
              32'(rq.pop_front()));
      end
      prev_done = bus.frame_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    res_t r;
    bus.RX_DV = 1'b0; bus.RX_ER = 1'b0; bus.RXD = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data_v",  32'(bus.rx_data_v),  32'd0);
    chk("rst_rx_data",    32'(bus.rx_data),    32'd0);
    chk("rst_rx_addr",    32'(bus.rx_addr),    32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_frame_ok",   32'(bus.frame_ok),   32'd0);
    chk("rst_frame_len",  32'(bus.frame_len),  32'd0);
    chk("rst_crc_err",    32'(bus.crc_err),    32'd0);
    chk("rst_len_err",    32'(bus.len_err),    32'd0);
    chk("rst_phy_err",    32'(bus.phy_err),    32'd0);
    rst = 1'b0;
    idle(2);

    // Good 64-byte frame (RX_ER during preamble must be ignored)
    make_frame(64, 3);
    send(-1, 8'hD5, 1'b1, mk(1, 0, 0, 0, 64));

    // Same frame, bit 0 of byte 10 flipped, back to back
    make_frame(64, 3);
    frm[10] = frm[10] ^ 8'h01;
    send(-1, 8'hD5, 1'b0, mk(0, 1, 0, 0, 64));

    // RX_ER at byte 20
    make_frame(64, 5);
    send(20, 8'hD5, 1'b0, mk(0, 0, 0, 1, 20));

    // Oversize stream, short frames, and a maximum-length good frame
    make_frame(1600, 7);
    send(-1, 8'hD5, 1'b0, mk(0, 0, 1, 0, 1522));
    make_frame(40, 9);
    send(-1, 8'hD5, 1'b0, mk(0, 0, 1, 0, 40));
    make_frame(63, 11);
    send(-1, 8'hD5, 1'b0, mk(0, 0, 1, 0, 63));
    make_frame(1522, 13);
    send(-1, 8'hD5, 1'b0, mk(1, 0, 0, 0, 1522));

    // Bad SFD
    send(-1, 8'hAB, 1'b0, mk(0, 0, 0, 0, 0));
    idle(3);

    // Reset at byte 30 with RX_DV held high
    preamble(1'b0);
    @(negedge clk);
    bus.RXD = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.RXD = 8'hA0;
      wq.push_back({11'(i), 8'hA0});
    end
    @(negedge clk);
    bus.RXD = 8'hA0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_frame_len", 32'(bus.frame_len), 32'd0);
    chk("mid_rst_rx_data_v", 32'(bus.rx_data_v), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.RX_DV = 1'b1; bus.RXD = 8'hA0;
    end
    idle(3);

    make_frame(64, 17);
    send(-1, 8'hD5, 1'b0, mk(1, 0, 0, 0, 64));
    idle(4);

    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("status_drained", 32'(rq.size()), 32'd0);
    r = mk(0, 0, 0, 0, 0);
    if (r.ok) idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_gmii_framer.md
RX_GMII_FRAMER -- requirements
Module: rx_gmii_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1522, the maximum accepted frame length in bytes (destination MAC through FCS).
REQ-002 SHALL have parameter MIN_LEN, default 64, the minimum accepted frame length in bytes.
REQ-003 SHALL be clocked by RX_CLK (input, 1) as its only clock; all logic runs on its rising edge.
REQ-004 SHALL have reset rst (input, 1): asynchronous, active-high.
REQ-005 RX_DV (input, 1): GMII receive data valid.
REQ-006 RXD (input, 8): GMII receive byte.
REQ-007 RX_ER (input, 1): GMII receive error.
REQ-008 rx_data_v (output, 1): write strobe to the RX frame SRAM.
REQ-009 rx_data (output, 8): byte to write.
REQ-010 rx_addr (output, 11): SRAM byte address, 0 = first byte after SFD.
REQ-011 frame_done (output, 1): one-cycle pulse at the end of any frame attempt that reached DATA or DROP.
REQ-012 frame_ok (output, 1): frame status, valid while frame_done=1.
REQ-013 frame_len (output, 11): bytes written, FCS included; held until the next frame_done.
REQ-014 crc_err, len_err, phy_err (outputs, 1 each): error cause, valid while frame_done=1.

Function
REQ-015 SHALL implement FSM states IDLE, PREAMBLE, DATA, DROP; RX_DV and RXD are sampled on each rising edge.
REQ-016 IDLE: RX_DV=1 with RXD=8'h55 -> PREAMBLE; any other input -> stay in IDLE.
REQ-017 PREAMBLE: RXD=8'h55 -> stay; RXD=8'hD5 -> DATA with byte count=0 and CRC=32'hFFFFFFFF; any other byte with RX_DV=1 -> DROP; RX_DV=0 -> IDLE, no frame_done.
REQ-018 DATA, each cycle with RX_DV=1 and RX_ER=0: next cycle drives rx_data_v=1, rx_data=RXD, rx_addr=count; then count+1 and CRC updated with the byte (one-cycle write latency).
REQ-019 CRC: reflected polynomial 32'hEDB88320, LSB first, no final inversion; after FCS bytes the register SHALL equal residue 32'hDEBB20E3 for a good frame.
REQ-020 DATA with RX_ER=1: no write; phy_err latched; -> DROP.
REQ-021 DATA with count=MAX_LEN and RX_DV=1: no write; len_err latched; -> DROP (addresses never exceed MAX_LEN-1).
REQ-022 DATA with RX_DV=0 -> IDLE; next cycle frame_done=1, frame_len=count, crc_err=(CRC!=residue), len_err=(count<MIN_LEN), frame_ok=no error flag set.
REQ-023 DROP: no writes; on RX_DV=0 -> IDLE and pulse frame_done next cycle with frame_ok=0, latched error flags, frame_len=count written so far.
REQ-024 PREAMBLE abort to DROP (bad SFD) SHALL end with frame_done, frame_ok=0, and all error flags 0.
REQ-025 RX_ER outside DATA SHALL be ignored.
REQ-026 rx_data_v SHALL be 0 in every cycle not produced by REQ-018; frame_done SHALL never be high on two consecutive cycles.
REQ-027 Back-to-back frames (one RX_DV=0 cycle of gap) SHALL both be received; count restarts at 0.

Reset
REQ-028 rst=1 SHALL force IDLE at once; rx_data_v=0, rx_data=0, rx_addr=0, frame_done=0, frame_ok=0, frame_len=0, all error flags 0, CRC=32'hFFFFFFFF.
REQ-029 Reset mid-frame SHALL abandon the frame without frame_done; after release the FSM waits in IDLE until a new preamble starts (REQ-016), even if RX_DV is still high.

Structure
REQ-030 Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY, CRC_INIT, CRC_RESIDUE and the state encoding SHALL live in shared package vthernet_pkg.
REQ-031 The byte-wise CRC update SHALL be a combinational sub-module crc32_d8 (inputs: crc_in[31:0], data[7:0]; output: crc_out[31:0]).

Verification
REQ-032 7x55 + D5, then a 64-byte frame with correct FCS -> rx_addr 0..63 written, frame_done with frame_ok=1, frame_len=64, all error flags 0.
REQ-033 Same frame with bit 0 of byte 10 flipped -> frame_ok=0, crc_err=1, frame_len=64.
REQ-034 RX_ER=1 at byte 20 -> writes stop at rx_addr 19, phy_err=1, frame_ok=0, frame_len=20.
REQ-035 1600-byte stream -> last write at rx_addr 1521, len_err=1, frame_len=1522; a 40-byte valid-FCS frame -> len_err=1.
REQ-036 Preamble followed by 8'hAB instead of SFD -> no writes, frame_done with frame_ok=0 and all flags 0.
REQ-037 rst pulsed at byte 30 with RX_DV held high -> no frame_done; the next good frame is received normally from rx_addr 0.
